// File: rtl/aes_cipher_core.sv
// Iterative AES block cipher core, one round per clock, AES-128/192/256 encrypt and decrypt.
// The caller supplies the fully expanded key schedule and holds it stable for the whole
// operation; the core stores only the data block, the round counter and the latched mode.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     data_in/mode valid          in_ready   core can accept a block (IDLE only)
//   mode         0 = encrypt, 1 = decrypt    data_in    input block, byte 0 = bits [0:7]
//   keySchedule  round keys, rk[r] = keySchedule[128*r +: 128]
//   out_valid    data_out holds a result     out_ready  consumer takes data_out
//   data_out     result block (zero unless out_valid)
//   busy         high while rounds are being computed (ROUND and FINAL)
module aes_cipher_core #(
    parameter  int unsigned NK = 4,
    localparam int unsigned NR = NK + 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [0:127]          data_in,
    input  logic [0:128*(NR+1)-1] keySchedule,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:127]          data_out,
    output logic                  busy
);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
        $error("aes_cipher_core: NK must be 4, 6 or 8");
    end

    localparam logic [3:0] NrW = 4'(NR);

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    // ---------------------------------------------------------------------------------------
    // GF(2^8) arithmetic and AES round primitives. Byte k of a block sits at [127-8k -: 8],
    // column c holds bytes 4c..4c+3.
    // ---------------------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] k);
        return mix_columns(shift_rows(sub_bytes(s))) ^ k;
    endfunction

    function automatic logic [127:0] encrypt_last_round(input logic [127:0] s,
                                                        input logic [127:0] k);
        return shift_rows(sub_bytes(s)) ^ k;
    endfunction

    // Straight inverse cipher: the round key is added before InvMixColumns.
    function automatic logic [127:0] decrypt_round(input logic [127:0] s, input logic [127:0] k);
        return inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ k);
    endfunction

    function automatic logic [127:0] decrypt_last_round(input logic [127:0] s,
                                                        input logic [127:0] k);
        return inv_sub_bytes(inv_shift_rows(s)) ^ k;
    endfunction

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [127:0]  data_q, data_d;
    logic [3:0]    rnd_q, rnd_d;
    logic          mode_q, mode_d;
    logic          ready_q;     // keeps in_ready low until the first edge after reset

    logic [3:0]    rk_idx;
    logic [10:0]   rk_base;
    logic [127:0]  rk;

    // Round-key index: the accept cycle still uses the live mode input, later states the
    // latched one. Decrypt walks the schedule backwards.
    always_comb begin
        rk_idx = 4'd0;
        unique case (state_q)
            StIdle:  rk_idx = mode ? NrW : 4'd0;
            StRound: rk_idx = mode_q ? (NrW - rnd_q) : rnd_q;
            StFinal: rk_idx = mode_q ? 4'd0 : NrW;
            default: rk_idx = 4'd0;
        endcase
    end

    assign rk_base = {rk_idx, 7'd0};
    assign rk      = keySchedule[rk_base +: 128];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    mode_d  = mode;
                    data_d  = data_in ^ rk;
                    rnd_d   = 4'd1;
                    state_d = StRound;
                end
            end
            StRound: begin
                data_d = mode_q ? decrypt_round(data_q, rk) : encrypt_round(data_q, rk);
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == NrW - 4'd1) state_d = StFinal;
            end
            StFinal: begin
                data_d  = mode_q ? decrypt_last_round(data_q, rk) : encrypt_last_round(data_q, rk);
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    rnd_d   = 4'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            rnd_q   <= 4'd0;
            mode_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            ready_q <= 1'b1;
        end
    end

    assign in_ready  = (state_q == StIdle) && ready_q;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRound) || (state_q == StFinal);
    assign data_out  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core: one NK=4 and one NK=8 instance sharing clock and reset.
module tb_aes_cipher_core;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KEY5 = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] PT5  = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] CT5  = 128'h29c3505f571420f6402299b31a02d73a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic            va, ma, ora, rdy_a, ov_a, busy_a;
    logic [0:127]    da, dout_a;
    logic [0:1407]   ksa;
    logic            vb, mb, orb, rdy_b, ov_b, busy_b;
    logic [0:127]    db, dout_b;
    logic [0:1919]   ksb;

    logic [7:0] sb [256];

    aes_cipher_core #(.NK(4)) u_dut_a (
        .clk(clk), .reset(rst_n), .in_valid(va), .in_ready(rdy_a), .mode(ma), .data_in(da),
        .keySchedule(ksa), .out_valid(ov_a), .out_ready(ora), .data_out(dout_a), .busy(busy_a)
    );

    aes_cipher_core #(.NK(8)) u_dut_b (
        .clk(clk), .reset(rst_n), .in_valid(vb), .in_ready(rdy_b), .mode(mb), .data_in(db),
        .keySchedule(ksb), .out_valid(ov_b), .out_ready(orb), .data_out(dout_b), .busy(busy_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[a] = s;
        end
    endtask

    function automatic logic [0:1919] key_expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1919] ks;
        int            nw;
        nw = 4 * (nk + 7);
        ks = '0;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gm(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [0:1919] ks,
                                               input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, o;
        logic [7:0]   a0, a1, a2, a3;
        rk = ks[0 +: 128];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
                    s[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
                end
            end
            rk = ks[128*r +: 128];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_key_a(input logic [127:0] key);
        logic [0:1919] ksf;
        ksf = key_expand({key, 128'h0}, 4);
        ksa = ksf[0 +: 1408];
    endtask

    // Offers one block, waits for accept and then for out_valid (both bounded). lat counts
    // clock edges from the accept edge (inclusive) to the edge after which out_valid is seen.
    task automatic drive_block(input bit big, input bit m, input logic [127:0] din,
                               output logic [127:0] dout, output int lat, output int acc);
        int n;
        n = 0; lat = -1; acc = -1; dout = 'x;
        if (big) begin vb = 1'b1; mb = m; db = din; end
        else     begin va = 1'b1; ma = m; da = din; end
        while (!(big ? rdy_b : rdy_a) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin va = 1'b0; vb = 1'b0; return; end
        @(posedge clk); #1;
        acc = cyc;
        // scramble inputs after accept; the block in flight must not notice
        if (big) begin vb = 1'b0; mb = ~m; db = ~din; end
        else     begin va = 1'b0; ma = ~m; da = ~din; end
        lat = 1;
        while (!(big ? ov_b : ov_a) && lat < 40) begin @(posedge clk); #1; lat++; end
        if (big ? ov_b : ov_a) dout = big ? dout_b : dout_a;
    endtask

    task automatic consume(input bit big);
        if (big) orb = 1'b1; else ora = 1'b1;
        @(posedge clk); #1;
        if (big) orb = 1'b0; else ora = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov_a); end
        n_tests++; if (dout_a !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", dout_a); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_tests++; if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b/%b want 0/0", rdy_a, rdy_b); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL in_ready_before_edge: got %b want 0", rdy_a); end
        @(posedge clk); #1;
        n_tests++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin n_fail++; $display("FAIL in_ready_first_edge: got %b/%b want 1/1", rdy_a, rdy_b); end
    endtask

    task automatic test_enc128();
        logic [127:0] d; int lat, acc;
        set_key_a(KEY1);
        drive_block(1'b0, 1'b0, PT1, d, lat, acc);
        n_tests++; if (d !== CT1) begin n_fail++; $display("FAIL enc128_data: got %h want %h", d, CT1); end
        n_tests++; if (lat != 11) begin n_fail++; $display("FAIL enc128_latency: got %0d want 11", lat); end
        consume(1'b0);
    endtask

    task automatic test_dec128();
        logic [127:0] d; int lat, acc;
        set_key_a(KEY2);
        drive_block(1'b0, 1'b1, CT2, d, lat, acc);
        n_tests++; if (d !== PT2) begin n_fail++; $display("FAIL dec128_data: got %h want %h", d, PT2); end
        n_tests++; if (lat != 11) begin n_fail++; $display("FAIL dec128_latency: got %0d want 11", lat); end
        consume(1'b0);
    endtask

    task automatic test_aes256();
        logic [127:0] d, p; int lat, acc;
        ksb = key_expand(KEY3, 8);
        drive_block(1'b1, 1'b0, PT2, d, lat, acc);
        n_tests++; if (d !== CT3) begin n_fail++; $display("FAIL enc256_data: got %h want %h", d, CT3); end
        n_tests++; if (lat != 15) begin n_fail++; $display("FAIL enc256_latency: got %0d want 15", lat); end
        consume(1'b1);
        drive_block(1'b1, 1'b1, d, p, lat, acc);
        n_tests++; if (p !== PT2) begin n_fail++; $display("FAIL dec256_data: got %h want %h", p, PT2); end
        n_tests++; if (lat != 15) begin n_fail++; $display("FAIL dec256_latency: got %0d want 15", lat); end
        consume(1'b1);
    endtask

    task automatic test_backpressure();
        logic [127:0] d; int lat, acc;
        set_key_a(KEY1);
        drive_block(1'b0, 1'b0, PT1, d, lat, acc);
        n_tests++; if (d !== CT1) begin n_fail++; $display("FAIL bp_first_data: got %h want %h", d, CT1); end
        // a new block is offered the whole time but must not be taken
        va = 1'b1; ma = 1'b1; da = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ov_a !== 1'b1 || dout_a !== CT1 || rdy_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b data=%h rdy=%b busy=%b want 1 %h 0 0",
                         i, ov_a, dout_a, rdy_a, busy_a, CT1);
            end
        end
        va = 1'b0;
        consume(1'b0);
        n_tests++; if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL bp_release: got ov=%b rdy=%b want 0 1", ov_a, rdy_a); end
    endtask

    task automatic test_reset_midrun();
        logic [127:0] d; int lat, acc; bit seen;
        set_key_a(KEY5);
        va = 1'b1; ma = 1'b0; da = PT1;
        @(posedge clk); #1;                // accept edge, round counter = 1
        va = 1'b0;
        repeat (4) @(posedge clk);         // round counter = 5
        #1;
        n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy_a); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL midrun_out_valid: got %b want 0", ov_a); end
        n_tests++; if (dout_a !== 128'h0) begin n_fail++; $display("FAIL midrun_data_out: got %h want 0", dout_a); end
        n_tests++; if (busy_a !== 1'b0 || rdy_a !== 1'b0) begin n_fail++; $display("FAIL midrun_busy_ready: got %b/%b want 0/0", busy_a, rdy_a); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin @(posedge clk); #1; if (ov_a) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrun_partial_output: got %b want 0", seen); end
        drive_block(1'b0, 1'b0, PT5, d, lat, acc);
        n_tests++; if (d !== CT5) begin n_fail++; $display("FAIL midrun_new_block: got %h want %h", d, CT5); end
        n_tests++; if (lat != 11) begin n_fail++; $display("FAIL midrun_latency: got %0d want 11", lat); end
        consume(1'b0);
    endtask

    task automatic test_stream();
        logic [0:1919] ksf;
        logic [127:0]  p, c, din, exp_v, d;
        logic          m;
        int            lat, acc, prev;
        set_key_a(KEY1);
        ksf  = key_expand({KEY1, 128'h0}, 4);
        ora  = 1'b1;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            m = (i < 2) ? (i == 1) : 1'($urandom_range(0, 1));
            p = {$urandom, $urandom, $urandom, $urandom};
            c = model_enc(p, ksf, 10);
            din   = m ? c : p;
            exp_v = m ? p : c;
            drive_block(1'b0, m, din, d, lat, acc);
            n_tests++; if (d !== exp_v) begin n_fail++; $display("FAIL stream_data[%0d] mode=%b: got %h want %h", i, m, d, exp_v); end
            if (i > 0) begin
                n_tests++; if (acc - prev != 12) begin n_fail++; $display("FAIL stream_interval[%0d]: got %0d want 12", i, acc - prev); end
            end
            prev = acc;
        end
        @(posedge clk); #1;
        ora = 1'b0;
        n_tests++; if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL stream_drain: got ov=%b rdy=%b want 0 1", ov_a, rdy_a); end
    endtask

    initial begin
        va = 1'b0; ma = 1'b0; da = '0; ora = 1'b0; ksa = '0;
        vb = 1'b0; mb = 1'b0; db = '0; orb = 1'b0; ksb = '0;
        build_sbox();
        test_reset();
        test_enc128();
        test_dec128();
        test_aes256();
        test_backpressure();
        test_reset_midrun();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
